// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - Avalon-MM read master that verifies the system-ID slave words
// Define SYSID_CHECK_RETRY_EN to re-run a failed check up to MAX_RETRIES extra times.
module sysid_check_master #(
    parameter logic [31:0] EXP_ID         = 32'h0000_0000,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1490495959,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          MAX_RETRIES    = 3,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempts
);

`ifdef SYSID_CHECK_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_WAIT,
        S_TS_REQ,
        S_TS_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;

    logic tmo_hit;
    logic in_read;
    logic got_resp;
    logic id_bad;
    logic ts_bad;
    logic abandon;
    logic check_bad;
    logic retry;
    logic new_check;
    logic launch;

    always_comb begin
        tmo_hit   = (tmo_cnt == TMO_LAST);
        in_read   = (state == S_ID_REQ) || (state == S_ID_WAIT) ||
                    (state == S_TS_REQ) || (state == S_TS_WAIT);
        got_resp  = readdatavalid && ((state == S_ID_WAIT) || (state == S_TS_WAIT));
        id_bad    = (id_value != EXP_ID);
        ts_bad    = (ts_value != EXP_TIMESTAMP);
        abandon   = in_read && !got_resp && tmo_hit;
        check_bad = (state == S_CHECK) && (id_bad || ts_bad);
        retry     = (abandon || check_bad) && RETRY_EN && (attempts < RETRY_LIMIT);
        // IDLE is only reachable from reset, so AUTO_START fires exactly once after release
        new_check = ((state == S_IDLE) && (start || (AUTO_START != 0))) ||
                    ((state == S_DONE) && start);
        launch    = new_check || retry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            address     <= 1'b0;
            read        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            attempts    <= '0;
        end else begin
            case (state)
                S_ID_REQ, S_TS_REQ: begin
                    if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (!waitrequest) begin
                            read  <= 1'b0;
                            state <= (state == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
                        end
                    end
                end
                S_ID_WAIT: begin
                    if (readdatavalid) begin
                        id_value <= readdata;
                        address  <= 1'b1;
                        read     <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_TS_REQ;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_TS_WAIT: begin
                    if (readdatavalid) begin
                        ts_value <= readdata;
                        state    <= S_CHECK;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    id_mismatch <= id_bad;
                    ts_mismatch <= ts_bad;
                    timeout     <= 1'b0;
                    pass        <= !(id_bad || ts_bad);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_DONE;
                end
                default: ;
            endcase

            // Abandoned read: mismatch flags deliberately keep their old values
            if (abandon) begin
                read    <= 1'b0;
                timeout <= 1'b1;
                pass    <= 1'b0;
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= S_DONE;
            end

            // A retry overrides the DONE transition above and keeps the failure flags visible
            if (launch) begin
                state   <= S_ID_REQ;
                read    <= 1'b1;
                address <= 1'b0;
                tmo_cnt <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
                if (new_check) begin
                    id_mismatch <= 1'b0;
                    ts_mismatch <= 1'b0;
                    timeout     <= 1'b0;
                    attempts    <= '0;
                end else begin
                    attempts <= attempts + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - randomized self-checking bench for sysid_check_master
module tb_sysid_check_master;

    localparam int          TO     = 16;
    localparam int          MAXR   = 2;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1490495959;
`ifdef SYSID_CHECK_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_mismatch;
    logic        ts_mismatch;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [3:0]  attempts;

    int total = 0;
    int bad   = 0;

    // per-attempt, per-word slave behaviour
    int          cfg_stall [4][2];
    int          cfg_lat   [4][2];
    logic [31:0] cfg_data  [4][2];
    int          attempt_idx;
    int          exp_word;
    logic [31:0] m_id;
    logic [31:0] m_ts;

    sysid_check_master #(
        .EXP_ID         (EXP_ID),
        .EXP_TIMESTAMP  (EXP_TS),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MAXR),
        .AUTO_START     (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .address       (address),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .id_mismatch   (id_mismatch),
        .ts_mismatch   (ts_mismatch),
        .timeout       (timeout),
        .id_value      (id_value),
        .ts_value      (ts_value),
        .attempts      (attempts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Avalon slave: stall, then respond after the configured latency unless that would be too late
    int          s_cyc = 0;
    int          s_pend = 0;
    int          s_pend_at = 0;
    int          s_pend_word = 0;
    logic [31:0] s_pend_data = '0;
    int          s_in_req = 0;
    int          s_req_s = 0;
    int          s_req_w = 0;
    int          s_att = 0;

    initial begin
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            @(posedge clock);
            #1;
            readdatavalid = 1'b0;
            readdata      = $urandom;
            if (!reset_n) begin
                s_pend      = 0;
                s_in_req    = 0;
                waitrequest = 1'b0;
            end else begin
                if (s_pend != 0 && s_pend_at == s_cyc) begin
                    readdatavalid = 1'b1;
                    readdata      = s_pend_data;
                    s_pend        = 0;
                    if (s_pend_word == 0) exp_word = 1;
                end
                if (read) begin
                    if (s_in_req == 0) begin
                        s_in_req = 1;
                        s_req_s  = 0;
                        s_req_w  = exp_word;
                        exp_word = 0;
                        if (s_req_w == 0 && attempt_idx < 3) attempt_idx++;
                    end
                    check_eq("address", 64'(address), 64'(s_req_w));
                    s_att = (attempt_idx < 0) ? 0 : attempt_idx;
                    if (s_req_s < cfg_stall[s_att][s_req_w]) begin
                        waitrequest = 1'b1;
                        s_req_s++;
                    end else begin
                        waitrequest = 1'b0;
                        s_in_req    = 0;
                        if (s_req_s + cfg_lat[s_att][s_req_w] < TO) begin
                            s_pend      = 1;
                            s_pend_at   = s_cyc + cfg_lat[s_att][s_req_w];
                            s_pend_word = s_req_w;
                            s_pend_data = cfg_data[s_att][s_req_w];
                        end
                    end
                end else begin
                    waitrequest = 1'b0;
                    s_in_req    = 0;
                end
            end
            s_cyc++;
        end
    end

    task automatic set_cfg(input int s, input int l, input logic [31:0] d0, input logic [31:0] d1);
        for (int a = 0; a < 4; a++) begin
            cfg_stall[a][0] = s;
            cfg_stall[a][1] = s;
            cfg_lat[a][0]   = l;
            cfg_lat[a][1]   = l;
            cfg_data[a][0]  = d0;
            cfg_data[a][1]  = d1;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_flags"}, 64'({address, read, busy, done, pass, id_mismatch,
                                       ts_mismatch, timeout, attempts}), 64'd0);
        check_eq({tag, "_values"}, {id_value, ts_value}, 64'd0);
    endtask

    // use_start=0 releases reset instead of pulsing start; poke pulses start while busy
    task automatic run_check(input bit use_start, input bit poke);
        int k;
        int e_k;
        int e_att;
        int d0;
        int d1;
        bit e_pass;
        bit e_idm;
        bit e_tsm;
        bit e_tmo;
        e_k   = 1;
        e_att = 0;
        e_idm = 0;
        e_tsm = 0;
        e_tmo = 0;
        e_pass = 0;
        for (int a = 0; a <= MAXR; a++) begin
            d0 = cfg_stall[a][0] + cfg_lat[a][0];
            d1 = cfg_stall[a][1] + cfg_lat[a][1];
            if (d0 >= TO) begin
                e_tmo = 1;
                e_k += TO;
            end else begin
                m_id = cfg_data[a][0];
                e_k += d0 + 1;
                if (d1 >= TO) begin
                    e_tmo = 1;
                    e_k += TO;
                end else begin
                    m_ts  = cfg_data[a][1];
                    e_k  += d1 + 2;
                    e_idm = (m_id != EXP_ID);
                    e_tsm = (m_ts != EXP_TS);
                    e_tmo = 0;
                end
            end
            e_pass = !e_tmo && !e_idm && !e_tsm;
            if (e_pass || !RETRY || a == MAXR) break;
            e_att++;
        end

        attempt_idx = -1;
        exp_word    = 0;
        if (use_start) start = 1'b1;
        else reset_n = 1'b1;
        k = 0;
        while (k < e_k + 40) begin
            k++;
            @(negedge clock);
            start = poke && (k == 2);
            if (k == 1) check_eq("busy_early", 64'(busy), 64'd1);
            if (done) break;
        end
        start = 1'b0;
        check_eq("latency", 64'(k), 64'(e_k));
        check_eq("done", 64'(done), 64'd1);
        check_eq("busy", 64'(busy), 64'd0);
        check_eq("read", 64'(read), 64'd0);
        check_eq("pass", 64'(pass), 64'(e_pass));
        check_eq("id_mismatch", 64'(id_mismatch), 64'(e_idm));
        check_eq("ts_mismatch", 64'(ts_mismatch), 64'(e_tsm));
        check_eq("timeout", 64'(timeout), 64'(e_tmo));
        check_eq("id_value", 64'(id_value), 64'(m_id));
        check_eq("ts_value", 64'(ts_value), 64'(m_ts));
        check_eq("attempts", 64'(attempts), 64'(e_att));
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        attempt_idx = -1;
        exp_word    = 0;
        m_id        = '0;
        m_ts        = '0;
        set_cfg(0, 1, EXP_ID, EXP_TS);
        repeat (3) @(negedge clock);
        check_zero("reset");

        // auto-start after reset release against a nominal slave
        run_check(1'b0, 1'b0);

        set_cfg(0, 1, 32'h0000_0001, EXP_TS);
        run_check(1'b1, 1'b0);

        set_cfg(0, 1, EXP_ID, EXP_TS);
        for (int a = 0; a < 4; a++) cfg_stall[a][1] = 5;
        run_check(1'b1, 1'b0);

        set_cfg(0, 100, EXP_ID, EXP_TS);
        run_check(1'b1, 1'b0);

        set_cfg(0, 1, 32'h0000_DEAD, EXP_TS);
        run_check(1'b1, 1'b0);

        set_cfg(0, 1, EXP_ID, EXP_TS);
        cfg_data[0][0] = 32'h0000_0BAD;
        run_check(1'b1, 1'b1);

        // reset while the timestamp read is outstanding
        set_cfg(0, 1, EXP_ID, EXP_TS);
        for (int a = 0; a < 4; a++) cfg_lat[a][1] = 10;
        attempt_idx = -1;
        exp_word    = 0;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clock);
        m_id = '0;
        m_ts = '0;
        set_cfg(0, 1, EXP_ID, EXP_TS);
        run_check(1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            for (int a = 0; a < 4; a++) begin
                for (int w = 0; w < 2; w++) begin
                    cfg_stall[a][w] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
                    cfg_lat[a][w]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20))
                                                                  : int'($urandom_range(1, 4));
                    cfg_data[a][w]  = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                                  : ((w == 1) ? EXP_TS : EXP_ID);
                end
            end
            run_check(1'b1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
